adder_avst: RTL and testbench

- Avalon-ST packet summing block with an 8-bit byte stream in and a one-beat result packet out.
- Each input packet is delimited by end_in on its last beat.
- It adds all data bytes of the packet and emits the sum as a single beat with end_out=1.
- It sits between an upstream AVST source and a downstream AVST sink, and supports full backpressure.

---
 rtl/adder_avst.sv | 90 +++++++++
 tb/tb_adder_avst.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_avst.sv
// Avalon-ST packet summer: adds every byte of an input packet and emits the sum as one beat.
// Define ADDER_AVST_SAT_EN to saturate the running sum instead of wrapping.
module adder_avst #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_in,
    input  logic              valid_in,
    input  logic              ready_out,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              end_out
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] acc;
    logic              first;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] sum;
    logic              accept;
    logic              consume;

    assign accept  = valid_in && ready_in;
    assign consume = valid_out && ready_out;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        wide = {1'b0, acc} + {1'b0, data_in};
`ifdef ADDER_AVST_SAT_EN
        sum = wide[DATA_W] ? '1 : wide[DATA_W-1:0];
`else
        sum = wide[DATA_W-1:0];
`endif
        if (first) begin
            sum = data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // A freshly accepted last beat wins over retiring the old result: back-to-back with no bubble.
    always_comb begin
        state_next = state;
        if (accept && end_in) begin
            state_next = HOLD;
        end else if (consume) begin
            state_next = ACCUM;
        end
    end

    always_comb begin
        ready_in  = reset && ((state == ACCUM) || ready_out);
        valid_out = (state == HOLD);
        end_out   = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            first    <= 1'b1;
            data_out <= '0;
        end else if (accept) begin
            if (end_in) begin
                data_out <= sum;
                acc      <= '0;
                first    <= 1'b1;
            end else begin
                acc   <= sum;
                first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_avst.sv
// Randomized self-checking bench for adder_avst against a packet-level sum model.
module tb_adder_avst;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              end_in;
    logic              valid_in;
    logic              ready_out;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              end_out;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: bytes of the open packet, sums awaiting consumption, visible output state.
    int                pkt[$];
    int                results[$];
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;

    adder_avst #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .end_in   (end_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .ready_in (ready_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .end_out  (end_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int packet_sum();
        int total = 0;
        foreach (pkt[i]) total += pkt[i];
`ifdef ADDER_AVST_SAT_EN
        return (total > 255) ? 255 : total;
`else
        return total % 256;
`endif
    endfunction

    // Drive one cycle of inputs at the falling edge, predict the coming rising edge, then check.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] d, input logic e,
                         input logic r);
        bit accept, consume;
        int s;
        reset     = rst;
        valid_in  = v;
        data_in   = v ? d : 8'($urandom);
        end_in    = v ? e : 1'($urandom);
        ready_out = r;
        #1;
        check("ready_in", ready_in, rst && (!exp_valid || r));
        accept  = v && ready_in;
        consume = valid_out && r;
        if (consume) begin
            if (results.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                check("result_order", data_out, results.pop_front());
            end
        end
        @(negedge clk);
        if (!rst) begin
            pkt.delete();
            results.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            if (accept) begin
                pkt.push_back(int'(d));
                if (e) begin
                    s = packet_sum();
                    pkt.delete();
                    results.push_back(s);
                    exp_valid = 1'b1;
                    exp_data  = 8'(s);
                end else if (consume) begin
                    exp_valid = 1'b0;
                end
            end else if (consume) begin
                exp_valid = 1'b0;
            end
        end
        check("valid_out", valid_out, exp_valid);
        check("end_out", end_out, exp_valid);
        check("data_out", data_out, exp_data);
    endtask

    initial begin
        exp_valid = 1'b0;
        exp_data  = '0;
        reset     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        end_in    = 1'b0;
        ready_out = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) cycle(0, 1, 8'd1, 1, 1);
        check("reset_data", data_out, 0);

        // 3,5,7 -> 15 one cycle after the last beat
        cycle(1, 1, 8'd3, 0, 1);
        cycle(1, 1, 8'd5, 0, 1);
        cycle(1, 1, 8'd7, 1, 1);
        check("sum_357", data_out, 15);
        check("sum_357_valid", valid_out, 1);
        cycle(1, 0, 8'd0, 0, 1);
        check("sum_357_retired", valid_out, 0);

        cycle(1, 1, 8'h2A, 1, 1);
        check("single_beat", data_out, 8'h2A);
        cycle(1, 0, 8'd0, 0, 1);

        cycle(1, 1, 8'd200, 0, 1);
        cycle(1, 1, 8'd100, 1, 1);
`ifdef ADDER_AVST_SAT_EN
        check("wrap_200_100", data_out, 255);
`else
        check("wrap_200_100", data_out, 44);
`endif
        cycle(1, 0, 8'd0, 0, 1);

        // Backpressure: result must hold and ready_in stay low
        cycle(1, 1, 8'd1, 0, 0);
        cycle(1, 1, 8'd2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 8'd9, 1, 0);
            check("bp_hold", data_out, 3);
        end
        cycle(1, 0, 8'd0, 0, 1);
        check("bp_released", valid_out, 0);

        // Back-to-back single beats with gaps of 0 and 3
        cycle(1, 1, 8'd10, 1, 1);
        cycle(1, 1, 8'd20, 1, 1);
        check("b2b_20", data_out, 20);
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'd0, 0, 1);
        cycle(1, 1, 8'd30, 1, 1);
        check("b2b_30", data_out, 30);
        cycle(1, 0, 8'd0, 0, 1);

        // Reset mid-packet discards the partial sum
        cycle(1, 1, 8'd9, 0, 1);
        cycle(1, 1, 8'd9, 0, 1);
        cycle(0, 1, 8'd9, 0, 1);
        cycle(1, 1, 8'd4, 1, 1);
        check("reset_mid_pkt", data_out, 4);
        cycle(1, 0, 8'd0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'd0, 0, 1);
        check("drained", results.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
